// File: rtl/nios_dbg_pkg.sv
// Shared definitions for the Nios II debug command bridge: default widths,
// IR channel codes and the command record type.
package nios_dbg_pkg;

  localparam int NIOS_IR_W    = 2;
  localparam int NIOS_DR_W    = 38;
  localparam int NIOS_ACT_BIT = 35;

  // IR channel codes for the default 2-bit IR
  typedef enum logic [NIOS_IR_W-1:0] {
    IR_OCIMEM    = 2'd0,
    IR_TRACECTRL = 2'd1,
    IR_BREAK     = 2'd2,
    IR_RSVD      = 2'd3
  } ir_code_e;

  // One captured debug command: IR at update-DR time plus the shifted DR word
  typedef struct packed {
    logic [NIOS_IR_W-1:0] ir;
    logic [NIOS_DR_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/nios_dbg_sync_edge.sv
// Level synchroniser from the TCK domain followed by a rising-edge detector.
// The pulse is derived from registered state only, so it is glitch-free.
module nios_dbg_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_level,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Shift the asynchronous level through the synchroniser chain and keep
  // the previous synchronised value for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_level};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/nios_dbg_cmd_bridge.sv
// System-clock side of the Nios II JTAG debug slave. Synchronises the
// update-IR/update-DR strobes, queues {IR, DR} commands in a small FIFO,
// releases them under valid/ready and raises per-channel action pulses.
module nios_dbg_cmd_bridge
  import nios_dbg_pkg::*;
#(
  parameter int IR_W        = NIOS_IR_W,
  parameter int DR_W        = NIOS_DR_W,
  parameter int ACT_BIT     = NIOS_ACT_BIT,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 2,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 vs_uir,
  input  logic                 vs_udr,
  input  logic [IR_W-1:0]      ir_in,
  input  logic [DR_W-1:0]      sr,
  input  logic                 cmd_ready,
  input  logic                 overrun_clr,
  output logic                 cmd_valid,
  output logic [IR_W-1:0]      cmd_ir,
  output logic [DR_W-1:0]      cmd_data,
  output logic [DR_W-1:0]      jdo,
  output logic [(2**IR_W)-1:0] take_action,
  output logic [(2**IR_W)-1:0] take_no_action,
  output logic                 overrun,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int N_CH = 2**IR_W;
  localparam int AW   = $clog2(DEPTH);

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [DR_W-1:0] data;
  } entry_t;

  logic            w_uir_p;
  logic            w_udr_p;
  logic [IR_W-1:0] r_ir_q;

  entry_t          r_mem [DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  entry_t          w_head;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;

  logic [DR_W-1:0]  r_jdo;
  logic [N_CH-1:0]  r_take_action;
  logic [N_CH-1:0]  r_take_no_action;
  logic             r_overrun;
  logic [CNT_W-1:0] r_drop_cnt;

  nios_dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_uir (
    .clk     (clk),
    .reset_n (reset_n),
    .i_level (vs_uir),
    .o_rise  (w_uir_p)
  );

  nios_dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_udr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_level (vs_udr),
    .o_rise  (w_udr_p)
  );

  // Pointer MSB distinguishes full from empty when the indices coincide
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign w_pop  = !w_empty && cmd_ready;
  assign w_push = w_udr_p && (!w_full || w_pop);
  assign w_drop = w_udr_p && w_full && !w_pop;

  // Latch the IR on update-IR; a same-cycle push still sees the old value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ir_q <= '0;
    else if (w_uir_p) r_ir_q <= ir_in;
  end

  // Circular command buffer; reset flushes pending entries
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= '{ir: r_ir_q, data: sr};
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // On each accepted command, publish its data and pulse its IR channel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_jdo            <= '0;
      r_take_action    <= '0;
      r_take_no_action <= '0;
    end else begin
      r_take_action    <= '0;
      r_take_no_action <= '0;
      if (w_pop) begin
        r_jdo                         <= w_head.data;
        r_take_action[w_head.ir]      <= w_head.data[ACT_BIT];
        r_take_no_action[w_head.ir]   <= ~w_head.data[ACT_BIT];
      end
    end
  end

  // Sticky overrun and saturating drop count; clear wins over a new drop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun  <= 1'b0;
      r_drop_cnt <= '0;
    end else if (overrun_clr) begin
      r_overrun  <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
      if (r_drop_cnt != {CNT_W{1'b1}}) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign cmd_valid      = !w_empty;
  assign cmd_ir         = w_head.ir;
  assign cmd_data       = w_head.data;
  assign jdo            = r_jdo;
  assign take_action    = r_take_action;
  assign take_no_action = r_take_no_action;
  assign overrun        = r_overrun;
  assign drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_nios_dbg_cmd_bridge.sv
// Self-checking bench for nios_dbg_cmd_bridge at default parameters.
// A queue-based model tracks accepted commands, drops and the overrun flag.
module tb_nios_dbg_cmd_bridge;
  import nios_dbg_pkg::*;

  localparam int IR_W  = 2;
  localparam int DR_W  = 38;
  localparam int ACT   = 35;
  localparam int DEPTH = 2;
  localparam int CMAX  = 255;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            vs_uir = 1'b0;
  logic            vs_udr = 1'b0;
  logic [IR_W-1:0] ir_in = '0;
  logic [DR_W-1:0] sr = '0;
  logic            cmd_ready = 1'b0;
  logic            overrun_clr = 1'b0;
  logic            cmd_valid;
  logic [IR_W-1:0] cmd_ir;
  logic [DR_W-1:0] cmd_data;
  logic [DR_W-1:0] jdo;
  logic [3:0]      take_action;
  logic [3:0]      take_no_action;
  logic            overrun;
  logic [7:0]      drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  cmd_t            q[$];
  logic [IR_W-1:0] m_ir = '0;
  int              m_drop = 0;
  logic            m_ovr = 1'b0;

  nios_dbg_cmd_bridge #(
    .IR_W(IR_W), .DR_W(DR_W), .ACT_BIT(ACT),
    .SYNC_STAGES(2), .DEPTH(DEPTH), .CNT_W(8)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vs_uir         (vs_uir),
    .vs_udr         (vs_udr),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_ready      (cmd_ready),
    .overrun_clr    (overrun_clr),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .cmd_data       (cmd_data),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .overrun        (overrun),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] chan(input logic [IR_W-1:0] ir);
    return 4'(1) << ir;
  endfunction

  function automatic logic [DR_W-1:0] rand_dr();
    return DR_W'({$urandom(), $urandom()});
  endfunction

  task automatic set_ir(input logic [IR_W-1:0] v);
    @(negedge clk);
    ir_in  = v;
    vs_uir = 1'b1;
    repeat (2) @(negedge clk);
    vs_uir = 1'b0;
    repeat (3) @(negedge clk);
    m_ir = v;
  endtask

  // One update-DR strobe with the consumer stalled; model decides push/drop
  task automatic strobe_dr(input logic [DR_W-1:0] d, input int hold);
    @(negedge clk);
    sr     = d;
    vs_udr = 1'b1;
    repeat (hold) @(negedge clk);
    vs_udr = 1'b0;
    repeat (3) @(negedge clk);
    if (q.size() < DEPTH) q.push_back('{ir: m_ir, data: d});
    else begin
      m_ovr = 1'b1;
      if (m_drop < CMAX) m_drop++;
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".overrun"}, 64'(overrun), 64'(m_ovr));
    check({tag, ".drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic clear_overrun();
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    m_ovr  = 1'b0;
    m_drop = 0;
  endtask

  // Pop every modelled entry back to back, checking head, jdo and pulses
  task automatic drain(input string tag);
    cmd_t e;
    logic [3:0] act, nact;
    @(negedge clk);
    cmd_ready = 1'b1;
    while (q.size() > 0) begin
      e = q.pop_front();
      check({tag, ".valid"}, 64'(cmd_valid), 64'(1));
      check({tag, ".cmd_ir"}, 64'(cmd_ir), 64'(e.ir));
      check({tag, ".cmd_data"}, 64'(cmd_data), 64'(e.data));
      @(negedge clk);
      act  = e.data[ACT] ? chan(e.ir) : 4'd0;
      nact = e.data[ACT] ? 4'd0 : chan(e.ir);
      check({tag, ".jdo"}, 64'(jdo), 64'(e.data));
      check({tag, ".take_action"}, 64'(take_action), 64'(act));
      check({tag, ".take_no_action"}, 64'(take_no_action), 64'(nact));
    end
    cmd_ready = 1'b0;
    check({tag, ".empty"}, 64'(cmd_valid), 64'(0));
    @(negedge clk);
    check({tag, ".act_idle"}, 64'(take_action), 64'(0));
    check({tag, ".nact_idle"}, 64'(take_no_action), 64'(0));
  endtask

  initial begin
    logic [DR_W-1:0] d;
    cmd_t            e;
    int              n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.valid", 64'(cmd_valid), 64'(0));
    check("rst.jdo", 64'(jdo), 64'(0));
    check("rst.act", 64'(take_action), 64'(0));
    check("rst.nact", 64'(take_no_action), 64'(0));
    check_flags("rst");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single command latency: pulse exactly SYNC_STAGES+1 edges after edge 0
    set_ir(IR_BREAK);
    d = rand_dr();
    d[ACT] = 1'b1;
    @(negedge clk);
    sr = d;
    cmd_ready = 1'b1;
    vs_udr = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) vs_udr = 1'b0;
      check($sformatf("lat.act%0d", k), 64'(take_action), 64'((k == 3) ? 4'b0100 : 4'b0000));
      check($sformatf("lat.nact%0d", k), 64'(take_no_action), 64'(0));
      if (k == 3) check("lat.jdo", 64'(jdo), 64'(d));
    end
    cmd_ready = 1'b0;
    check("lat.empty", 64'(cmd_valid), 64'(0));

    // No-action path on the OCIMEM channel
    set_ir(IR_OCIMEM);
    d = rand_dr();
    d[ACT] = 1'b0;
    strobe_dr(d, 4);
    drain("noact");

    // Overrun: three strobes into a stalled two-entry FIFO
    set_ir(IR_TRACECTRL);
    for (int i = 0; i < 3; i++) strobe_dr(rand_dr(), 1 + i);
    check("ovr.valid", 64'(cmd_valid), 64'(1));
    check_flags("ovr");
    clear_overrun();
    check_flags("ovr_clr");
    drain("ovr");

    // Push into a full FIFO in the same cycle as a pop
    set_ir(IR_BREAK);
    strobe_dr(rand_dr(), 2);
    set_ir(IR_RSVD);
    strobe_dr(rand_dr(), 2);
    set_ir(IR_OCIMEM);
    d = rand_dr();
    @(negedge clk);
    sr = d;
    vs_udr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    vs_udr = 1'b0;
    e = q.pop_front();
    q.push_back('{ir: m_ir, data: d});
    check("simul.jdo", 64'(jdo), 64'(e.data));
    check("simul.act", 64'(take_action), 64'(e.data[ACT] ? chan(e.ir) : 4'd0));
    repeat (3) @(negedge clk);
    check_flags("simul");
    drain("simul");

    // Randomised rounds of 1..3 strobes with random IR/DR and hold lengths
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        set_ir(IR_W'($urandom_range(0, 3)));
        strobe_dr(rand_dr(), $urandom_range(1, 6));
      end
      check_flags($sformatf("rnd%0d", r));
      clear_overrun();
      drain($sformatf("rnd%0d", r));
    end

    // Saturation: 300 drops on a full FIFO
    set_ir(IR_BREAK);
    strobe_dr(rand_dr(), 1);
    strobe_dr(rand_dr(), 1);
    for (int i = 0; i < 300; i++) strobe_dr(rand_dr(), 1);
    check_flags("sat");
    check("sat.cnt255", 64'(drop_cnt), 64'(CMAX));

    // Reset with two commands queued flushes them without pulses
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    m_ir = '0;
    m_ovr = 1'b0;
    m_drop = 0;
    @(negedge clk);
    cmd_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rstmid.valid", 64'(cmd_valid), 64'(0));
      check("rstmid.act", 64'(take_action), 64'(0));
      check("rstmid.nact", 64'(take_no_action), 64'(0));
    end
    cmd_ready = 1'b0;
    check_flags("rstmid");
    check("rstmid.jdo", 64'(jdo), 64'(0));

    // Next command after reset works normally, using the reset IR of zero
    strobe_dr(rand_dr(), 2);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
